// File: rtl/tc_pl_cap_dac_spi.sv
`default_nettype none
//==============================================================================
// Module   : tc_pl_cap_dac_spi
// Brief    : Serial driver for the capture-path dual offset DAC (DAC0).
//            Latches one pair of channel codes and saturates each code to the
//            DAC range. Sends two mode-0 SPI frames {CMD, payload}, MSB first:
//            channel A, then a CSN-high gap, then channel B. Pulses done when
//            the transfer completes.
// Revision : 1.0 - initial release
//==============================================================================
module tc_pl_cap_dac_spi #(
    parameter int unsigned CODE_W  = 32,
    parameter int unsigned DAC_W   = 16,
    parameter int unsigned SCK_DIV = 4,
    parameter int unsigned CS_GAP  = 8,
    parameter logic [7:0]  CMD_A   = 8'h18,
    parameter logic [7:0]  CMD_B   = 8'h19
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code_a,
    input  logic [CODE_W-1:0] code_b,
    output logic              busy,
    output logic              done,
    output logic              ovr,
    output logic              DAC0_SCK,
    output logic              DAC0_CSN,
    output logic              DAC0_SDI
);

    localparam int unsigned FRAME_W = 8 + DAC_W;
    localparam int unsigned PH_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(SCK_DIV - 1);
    localparam logic [PH_W-1:0]  c_ph_one   = PH_W'(1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] c_bit_one  = BIT_W'(1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);
    localparam logic [DAC_W-1:0] c_pay_max  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME_A = 2'd1,
        ST_GAP     = 2'd2,
        ST_FRAME_B = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;        // cycles spent in current SCK phase
    logic [BIT_W-1:0]     bit_q, bit_d;      // index of bit on the wire (0 = MSB)
    logic [GAP_W-1:0]     gap_q, gap_d;      // cycles spent with CSN high between frames
    logic [FRAME_W-2:0]   shreg_q, shreg_d;  // bits still to be sent after the current one
    logic [DAC_W-1:0]     pay_b_q, pay_b_d;  // channel B payload held through frame A
    logic                 sck_q, sck_d;
    logic                 csn_q, csn_d;
    logic                 sdi_q, sdi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    logic [DAC_W-1:0]     w_pay_a;
    logic [DAC_W-1:0]     w_pay_b;
    logic                 w_sat_a;
    logic                 w_sat_b;
    logic [FRAME_W-1:0]   w_frame_a;
    logic [FRAME_W-1:0]   w_frame_b;

    // Clamp codes above the DAC full scale; narrower codes can never saturate.
    generate
        if (CODE_W > DAC_W) begin : g_sat
            assign w_sat_a = |code_a[CODE_W-1:DAC_W];
            assign w_sat_b = |code_b[CODE_W-1:DAC_W];
            assign w_pay_a = w_sat_a ? c_pay_max : code_a[DAC_W-1:0];
            assign w_pay_b = w_sat_b ? c_pay_max : code_b[DAC_W-1:0];
        end else begin : g_nosat
            assign w_sat_a = 1'b0;
            assign w_sat_b = 1'b0;
            assign w_pay_a = DAC_W'(code_a);
            assign w_pay_b = DAC_W'(code_b);
        end
    endgenerate

    // Frame A is built from the live inputs at acceptance; frame B from the held payload.
    assign w_frame_a = {CMD_A, w_pay_a};
    assign w_frame_b = {CMD_B, pay_b_q};

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        pay_b_d = pay_b_q;
        sck_d   = sck_q;
        csn_d   = csn_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FRAME_A;
                    pay_b_d = w_pay_b;
                    ovr_d   = w_sat_a | w_sat_b;
                    sdi_d   = w_frame_a[FRAME_W-1];
                    shreg_d = w_frame_a[FRAME_W-2:0];
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    ph_d    = '0;
                    bit_d   = '0;
                end
            end

            ST_FRAME_A, ST_FRAME_B: begin
                if (ph_q != c_ph_last) begin
                    ph_d = ph_q + c_ph_one;
                end else begin
                    ph_d = '0;
                    if (!sck_q) begin
                        // End of low phase: DAC samples on this rise.
                        sck_d = 1'b1;
                    end else if (bit_q != c_bit_last) begin
                        // End of high phase: fall and present the next bit.
                        sck_d   = 1'b0;
                        bit_d   = bit_q + c_bit_one;
                        sdi_d   = shreg_q[FRAME_W-2];
                        shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
                    end else begin
                        // Last high phase finished: deselect on the same edge SCK drops.
                        sck_d = 1'b0;
                        csn_d = 1'b1;
                        sdi_d = 1'b0;
                        if (state_q == ST_FRAME_A) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_q != c_gap_last) begin
                    gap_d = gap_q + c_gap_one;
                end else begin
                    state_d = ST_FRAME_B;
                    sdi_d   = w_frame_b[FRAME_W-1];
                    shreg_d = w_frame_b[FRAME_W-2:0];
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    ph_d    = '0;
                    bit_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk125 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            pay_b_q <= '0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            pay_b_q <= pay_b_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ovr      = ovr_q;
    assign DAC0_SCK = sck_q;
    assign DAC0_CSN = csn_q;
    assign DAC0_SDI = sdi_q;

endmodule
`default_nettype wire
